// File: rtl/axi4_master_pkg.sv
// axi4_master_pkg
// Shared types and helpers for the AXI4 master burst engine:
//   state_t     - engine FSM states
//   RESP_*      - AXI response encodings
//   BURST_*     - AXI burst-type encodings
//   resp_worse  - picks the more severe of two responses
//   cmd_legal   - size / burst-type / wrap-length legality of a command
package axi4_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Severity rank: DECERR > SLVERR > OKAY > EXOKAY. EXOKAY ranks lowest
    // so it can seed the read accumulator and be displaced by any real beat.
    function automatic logic [1:0] resp_rank(input logic [1:0] r);
        logic [1:0] rank;
        case (r)
            RESP_DECERR: rank = 2'd3;
            RESP_SLVERR: rank = 2'd2;
            RESP_OKAY:   rank = 2'd1;
            default:     rank = 2'd0;
        endcase
        return rank;
    endfunction

    function automatic logic [1:0] resp_worse(input logic [1:0] a, input logic [1:0] b);
        return (resp_rank(a) >= resp_rank(b)) ? a : b;
    endfunction

    // Beat-count limit against MAX_BURST_LEN is checked by the caller, which
    // owns that parameter.
    function automatic logic cmd_legal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input int data_bytes);
        logic ok;
        int   beat_bytes;
        ok         = 1'b1;
        beat_bytes = 1 << size;
        if (beat_bytes > data_bytes) ok = 1'b0;
        if (burst == BURST_RSVD) ok = 1'b0;
        if (burst == BURST_WRAP &&
            !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// axi4_if
// AXI4 bus bundle shared by the burst engine and its slave.
//   Parameters DATA_WIDTH / ADDR_WIDTH / ID_WIDTH size the payload fields.
//   modport master: drives AW/W/AR payload+VALID and BREADY/RREADY.
interface axi4_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_master_cmd_check.sv
// axi4_master_cmd_check
// Combinational legality check of the incoming command plus a register that
// captures the command when the engine accepts it.
//   clk, reset         - clock, async active-high reset
//   capture            - accept strobe from the engine FSM
//   cmd_*              - raw command fields
//   legal              - command is legal (combinational on cmd_*)
//   q_write..q_burst   - captured command, stable for the whole burst
module axi4_master_cmd_check
    import axi4_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  legal,
    output logic                  q_write,
    output logic [ADDR_WIDTH-1:0] q_addr,
    output logic [7:0]            q_len,
    output logic [2:0]            q_size,
    output logic [1:0]            q_burst
);

    localparam int         DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [8:0] LEN_LIMIT  = 9'(MAX_BURST_LEN - 1);

    always_comb begin
        legal = cmd_legal(cmd_len, cmd_size, cmd_burst, DATA_BYTES) &&
                ({1'b0, cmd_len} <= LEN_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_write <= 1'b0;
            q_addr  <= '0;
            q_len   <= '0;
            q_size  <= '0;
            q_burst <= '0;
        end else if (capture) begin
            q_write <= cmd_write;
            q_addr  <= cmd_addr;
            q_len   <= cmd_len;
            q_size  <= cmd_size;
            q_burst <= cmd_burst;
        end
    end

endmodule

// File: rtl/axi4_master_burst_engine.sv
// axi4_master_burst_engine
// Turns one command into a complete AXI4 write or read burst.
//   clk, reset              - clock, async active-high reset
//   master                  - AXI4 master modport
//   cmd_*                   - command handshake and fields (len = beats-1)
//   wd_*                    - write-beat stream, passed through to W
//   rd_*                    - read-beat stream, passed through from R
//   done_valid/resp/err     - one-cycle completion with worst response
// Optional build macro AXI4_MASTER_BURST_ENGINE_STATS_EN adds saturating
// counters stat_wr_bursts, stat_rd_bursts, stat_err and stat_busy_cycles.
module axi4_master_burst_engine
    import axi4_master_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int MAX_BURST_LEN = 16,
    parameter int ID_VALUE      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    axi4_if.master                  master,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    done_err
`ifdef AXI4_MASTER_BURST_ENGINE_STATS_EN
    ,
    output logic [31:0]             stat_wr_bursts,
    output logic [31:0]             stat_rd_bursts,
    output logic [15:0]             stat_err,
    output logic [31:0]             stat_busy_cycles
`endif
);

    state_t state, next_state;

    logic                  cmd_ok;
    logic                  accept;
    logic                  q_write;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [7:0]            q_len;
    logic [2:0]            q_size;
    logic [1:0]            q_burst;

    logic [7:0]            beat_count;
    logic [1:0]            resp_acc;
    logic                  err_acc;
    logic                  rejected;

    logic                  idle_ready;
    logic                  aw_phase;
    logic                  w_phase;
    logic                  b_phase;
    logic                  ar_phase;
    logic                  r_phase;
    logic                  done_phase;
    logic                  last_beat;
    logic                  w_fire;
    logic                  r_fire;

    assign accept = (state == ST_IDLE) && cmd_valid;

    axi4_master_cmd_check #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_BURST_LEN(MAX_BURST_LEN)
    ) u_cmd_check (
        .clk      (clk),
        .reset    (reset),
        .capture  (accept),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_size (cmd_size),
        .cmd_burst(cmd_burst),
        .legal    (cmd_ok),
        .q_write  (q_write),
        .q_addr   (q_addr),
        .q_len    (q_len),
        .q_size   (q_size),
        .q_burst  (q_burst)
    );

    assign last_beat = (beat_count == q_len);
    assign w_fire    = w_phase && wd_valid && master.wready;
    assign r_fire    = r_phase && master.rvalid && rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        idle_ready = 1'b0;
        aw_phase   = 1'b0;
        w_phase    = 1'b0;
        b_phase    = 1'b0;
        ar_phase   = 1'b0;
        r_phase    = 1'b0;
        done_phase = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd_ok)        next_state = ST_DONE;
                    else if (cmd_write) next_state = ST_AW;
                    else                next_state = ST_AR;
                end
            end
            ST_AW: begin
                aw_phase = 1'b1;
                if (master.awready) next_state = ST_W;
            end
            ST_W: begin
                w_phase = 1'b1;
                if (wd_valid && master.wready && last_beat) next_state = ST_B;
            end
            ST_B: begin
                b_phase = 1'b1;
                if (master.bvalid) next_state = ST_DONE;
            end
            ST_AR: begin
                ar_phase = 1'b1;
                if (master.arready) next_state = ST_R;
            end
            ST_R: begin
                r_phase = 1'b1;
                if (master.rvalid && rd_ready && master.rlast) next_state = ST_DONE;
            end
            ST_DONE: begin
                done_phase = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Beat counting and response/error accumulation. A rejected command
    // seeds SLVERR + error; a legal one seeds EXOKAY so the first real
    // response always replaces it. On reads, RLAST must coincide with the
    // final expected beat; any disagreement flags an error but the burst
    // still runs until the slave's RLAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
            resp_acc   <= RESP_OKAY;
            err_acc    <= 1'b0;
            rejected   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        beat_count <= '0;
                        rejected   <= !cmd_ok;
                        err_acc    <= !cmd_ok;
                        resp_acc   <= cmd_ok ? RESP_EXOKAY : RESP_SLVERR;
                    end
                end
                ST_W: begin
                    if (w_fire) beat_count <= beat_count + 8'd1;
                end
                ST_B: begin
                    if (master.bvalid) resp_acc <= master.bresp;
                end
                ST_R: begin
                    if (r_fire) begin
                        beat_count <= beat_count + 8'd1;
                        resp_acc   <= resp_worse(resp_acc, master.rresp);
                        if (master.rlast != last_beat) err_acc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cmd_ready is masked by reset so every output reads 0 during reset.
    assign cmd_ready = idle_ready && !reset;

    assign master.awid    = ID_WIDTH'(ID_VALUE);
    assign master.awaddr  = q_addr;
    assign master.awlen   = q_len;
    assign master.awsize  = q_size;
    assign master.awburst = q_burst;
    assign master.awlock  = 1'b0;
    assign master.awcache = 4'd0;
    assign master.awprot  = 3'd0;
    assign master.awqos   = 4'd0;
    assign master.awvalid = aw_phase;

    assign master.wvalid  = w_phase && wd_valid;
    assign master.wdata   = w_phase ? wd_data : '0;
    assign master.wstrb   = w_phase ? wd_strb : '0;
    assign master.wlast   = w_phase && last_beat;
    assign wd_ready       = w_phase && master.wready;

    assign master.bready  = b_phase;

    assign master.arid    = ID_WIDTH'(ID_VALUE);
    assign master.araddr  = q_addr;
    assign master.arlen   = q_len;
    assign master.arsize  = q_size;
    assign master.arburst = q_burst;
    assign master.arlock  = 1'b0;
    assign master.arcache = 4'd0;
    assign master.arprot  = 3'd0;
    assign master.arqos   = 4'd0;
    assign master.arvalid = ar_phase;

    assign master.rready  = r_phase && rd_ready;
    assign rd_valid       = r_phase && master.rvalid;
    assign rd_data        = r_phase ? master.rdata : '0;
    assign rd_last        = r_phase && master.rlast;

    assign done_valid     = done_phase;
    assign done_resp      = done_phase ? resp_acc : RESP_OKAY;
    assign done_err       = done_phase && err_acc;

`ifdef AXI4_MASTER_BURST_ENGINE_STATS_EN
    // Saturating activity counters. Rejected commands count only as errors,
    // never as completed bursts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_bursts   <= '0;
            stat_rd_bursts   <= '0;
            stat_err         <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (done_phase && !rejected && q_write && stat_wr_bursts != '1)
                stat_wr_bursts <= stat_wr_bursts + 32'd1;
            if (done_phase && !rejected && !q_write && stat_rd_bursts != '1)
                stat_rd_bursts <= stat_rd_bursts + 32'd1;
            if (done_phase && (err_acc || resp_acc != RESP_OKAY) && stat_err != '1)
                stat_err <= stat_err + 16'd1;
            if (state != ST_IDLE && stat_busy_cycles != '1)
                stat_busy_cycles <= stat_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_master_burst_engine.sv
// tb_axi4_master_burst_engine
// Directed scoreboard bench for axi4_master_burst_engine with a zero-wait
// AXI4 slave model. Expected address, W-beat, read-beat and completion
// records are queued as commands are issued; a monitor pops them when the
// DUT presents the matching handshake.
module tb_axi4_master_burst_engine;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } addr_exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_exp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       err;
        logic       bus;
    } done_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic          wd_valid = 1'b0;
    logic          wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic [7:0]    wd_strb = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          done_err;
`ifdef AXI4_MASTER_BURST_ENGINE_STATS_EN
    logic [31:0]   stat_wr_bursts;
    logic [31:0]   stat_rd_bursts;
    logic [15:0]   stat_err;
    logic [31:0]   stat_busy_cycles;
`endif

    axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi4_master_burst_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(16), .ID_VALUE(0)
    ) dut (
        .clk(clk), .reset(reset), .master(bus),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err)
`ifdef AXI4_MASTER_BURST_ENGINE_STATS_EN
        ,
        .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
        .stat_err(stat_err), .stat_busy_cycles(stat_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;

    addr_exp_t exp_addr[$];
    beat_exp_t exp_w[$];
    beat_exp_t exp_rd[$];
    done_exp_t exp_done[$];

    // Slave model controls set by the stimulus.
    logic [1:0] slave_bresp = 2'b00;
    logic [7:0] rlast_at = 8'd0;
    logic [1:0] rresp_tab [0:255];

    logic       s_bvalid;
    logic       r_active;
    logic [7:0] r_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_bvalid <= 1'b0;
            r_active <= 1'b0;
            r_idx    <= 8'd0;
        end else begin
            if (bus.wvalid && bus.wready && bus.wlast) s_bvalid <= 1'b1;
            else if (s_bvalid && bus.bready)           s_bvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                r_active <= 1'b1;
                r_idx    <= 8'd0;
            end else if (r_active && bus.rready) begin
                if (bus.rlast) r_active <= 1'b0;
                else           r_idx <= r_idx + 8'd1;
            end
        end
    end

    assign bus.awready = 1'b1;
    assign bus.wready  = 1'b1;
    assign bus.arready = 1'b1;
    assign bus.bvalid  = s_bvalid;
    assign bus.bresp   = slave_bresp;
    assign bus.bid     = '0;
    assign bus.rvalid  = r_active;
    assign bus.rdata   = 64'(r_idx);
    assign bus.rresp   = rresp_tab[r_idx];
    assign bus.rlast   = r_active && (r_idx == rlast_at);
    assign bus.rid     = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 2 time units after each falling edge, when inputs
    // driven on that edge have settled and the next rising edge is ahead.
    int last_evt = 0;
    int bus_cnt = 0;
    initial begin
        addr_exp_t a;
        beat_exp_t b;
        done_exp_t d;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (cmd_valid && cmd_ready) begin
                    last_evt = cyc;
                    bus_cnt  = 0;
                end
                if (bus.awvalid || bus.arvalid) bus_cnt++;
                if (bus.awvalid && bus.awready || bus.arvalid && bus.arready) begin
                    checkOutput("addr_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) begin
                        a = exp_addr.pop_front();
                        if (bus.awvalid) begin
                            checkOutput("aw_is_write", a.wr, 1);
                            checkOutput("aw_latency", cyc, last_evt + 1);
                            checkOutput("aw_fields", {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                                        {a.addr, a.len, a.size, a.burst});
                        end else begin
                            checkOutput("ar_is_read", a.wr, 0);
                            checkOutput("ar_latency", cyc, last_evt + 1);
                            checkOutput("ar_fields", {bus.araddr, bus.arlen, bus.arsize, bus.arburst},
                                        {a.addr, a.len, a.size, a.burst});
                        end
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    checkOutput("w_expected", exp_w.size() > 0, 1);
                    if (exp_w.size() > 0) begin
                        b = exp_w.pop_front();
                        checkOutput("w_data", bus.wdata, b.data);
                        checkOutput("w_strb_last", {bus.wstrb, bus.wlast}, {b.strb, b.last});
                    end
                end
                if (bus.bvalid && bus.bready) last_evt = cyc;
                if (rd_valid && rd_ready) begin
                    checkOutput("rd_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) begin
                        b = exp_rd.pop_front();
                        checkOutput("rd_data", rd_data, b.data);
                        checkOutput("rd_last", rd_last, b.last);
                    end
                end
                if (bus.rvalid && bus.rready && bus.rlast) last_evt = cyc;
                if (done_valid) begin
                    checkOutput("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        d = exp_done.pop_front();
                        checkOutput("done_resp", done_resp, d.resp);
                        checkOutput("done_err", done_err, d.err);
                        checkOutput("done_latency", cyc, last_evt + 1);
                        checkOutput("done_bus_activity", bus_cnt != 0, d.bus);
                        checkOutput("done_cmd_ready_low", cmd_ready, 0);
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input logic bus_exp);
        int n = 0;
        addr_exp_t a;
        if (bus_exp) begin
            a = '{wr: wr, addr: addr, len: len, size: size, burst: burst};
            exp_addr.push_back(a);
        end
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic driveWriteBeats(input int nbeats, input logic [63:0] base);
        int n;
        wd_valid = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            wd_data = base + 64'(b);
            wd_strb = 8'hFF ^ 8'(b);
            n = 0;
            while (!wd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkOutput("wd_ready_wait", wd_ready, 1);
            @(negedge clk);
        end
        wd_valid = 1'b0;
    endtask

    task automatic waitDone(input int target, input logic throttle);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            if (throttle) rd_ready = ~rd_ready;
            n++;
        end
        rd_ready = 1'b1;
        checkOutput("done_wait", done_cnt >= target, 1);
    endtask

    task automatic pushWriteBeats(input int nbeats, input logic [7:0] len, input logic [63:0] base);
        beat_exp_t b;
        for (int i = 0; i < nbeats; i++) begin
            b = '{data: base + 64'(i), strb: 8'hFF ^ 8'(i), last: (8'(i) == len)};
            exp_w.push_back(b);
        end
    endtask

    task automatic runWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] bresp, input logic [63:0] base);
        int tgt;
        done_exp_t d;
        slave_bresp = bresp;
        pushWriteBeats(int'(len) + 1, len, base);
        d = '{resp: bresp, err: 1'b0, bus: 1'b1};
        exp_done.push_back(d);
        tgt = done_cnt + 1;
        applyStimulus(1'b1, addr, len, size, 2'b01, 1'b1);
        driveWriteBeats(int'(len) + 1, base);
        waitDone(tgt, 1'b0);
    endtask

    task automatic runRead(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] last_pos, input logic throttle,
                           input logic [1:0] resp, input logic err);
        int tgt;
        beat_exp_t b;
        done_exp_t d;
        rlast_at = last_pos;
        for (int i = 0; i <= int'(last_pos); i++) begin
            b = '{data: 64'(i), strb: 8'h00, last: (8'(i) == last_pos)};
            exp_rd.push_back(b);
        end
        d = '{resp: resp, err: err, bus: 1'b1};
        exp_done.push_back(d);
        tgt = done_cnt + 1;
        rd_ready = 1'b1;
        applyStimulus(1'b0, addr, len, 3'd3, burst, 1'b1);
        waitDone(tgt, throttle);
    endtask

    task automatic runReject(input logic wr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
        int tgt;
        done_exp_t d;
        d = '{resp: 2'b10, err: 1'b1, bus: 1'b0};
        exp_done.push_back(d);
        tgt = done_cnt + 1;
        applyStimulus(wr, 32'h0000_6000, len, size, burst, 1'b0);
        waitDone(tgt, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rresp_tab[i] = 2'b00;

        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        checkOutput("reset_streams", {wd_ready, rd_valid, rd_last, done_valid, done_err, done_resp}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", cmd_ready, 1);

        // INCR write, 4 beats, OKAY.
        runWrite(32'h0000_1000, 8'd3, 3'd3, 2'b00, 64'hA5A5_0000_0000_0000);
        // Single-beat write with SLVERR response.
        runWrite(32'h0000_1800, 8'd0, 3'd2, 2'b10, 64'h0000_0000_1234_0000);

        // Throttled 8-beat read.
        runRead(32'h0000_2000, 8'd7, 2'b01, 8'd7, 1'b1, 2'b00, 1'b0);

        // Illegal commands: len 16, WRAP len 2, oversize beat, reserved burst.
        runReject(1'b1, 8'd16, 3'd3, 2'b01);
        runReject(1'b0, 8'd2, 3'd3, 2'b10);
        runReject(1'b0, 8'd0, 3'd4, 2'b01);
        runReject(1'b1, 8'd0, 3'd3, 2'b11);

        // Longest legal burst, WRAP with len 15.
        runRead(32'h0000_5000, 8'd15, 2'b10, 8'd15, 1'b0, 2'b00, 1'b0);

        // Mixed read responses: OKAY, SLVERR, OKAY, DECERR.
        rresp_tab[0] = 2'b00;
        rresp_tab[1] = 2'b10;
        rresp_tab[2] = 2'b00;
        rresp_tab[3] = 2'b11;
        runRead(32'h0000_2100, 8'd3, 2'b01, 8'd3, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) rresp_tab[i] = 2'b00;

        // Early RLAST on beat 1 of a 4-beat read.
        runRead(32'h0000_2200, 8'd3, 2'b01, 8'd1, 1'b0, 2'b00, 1'b1);
        checkOutput("idle_after_mismatch", cmd_ready, 1);

        // Reset after 2 of 4 write beats; no completion for the aborted burst.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pushWriteBeats(2, 8'd3, 64'hBEEF_0000_0000_0000);
        applyStimulus(1'b1, 32'h0000_3000, 8'd3, 3'd3, 2'b01, 1'b1);
        driveWriteBeats(2, 64'hBEEF_0000_0000_0000);
        reset = 1'b1;
        #1;
        checkOutput("midreset_valids", {bus.awvalid, bus.wvalid, done_valid, cmd_ready}, 0);
        repeat (2) @(negedge clk);
        checkOutput("midreset_hold", {bus.awvalid, bus.wvalid, bus.bready, done_valid}, 0);
        reset = 1'b0;
        runWrite(32'h0000_4000, 8'd1, 3'd3, 2'b00, 64'hC0DE_0000_0000_0000);
`ifdef AXI4_MASTER_BURST_ENGINE_STATS_EN
        checkOutput("stat_wr_bursts", stat_wr_bursts, 1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("leftover_queues", exp_addr.size() + exp_w.size() + exp_rd.size() + exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi4_master_burst_engine.md
Name: axi4_master_burst_engine

Overview:
- Parameterised, synthesisable AXI4 master that turns single-burst commands into complete AXI4 write or read transactions.
- It is the next generation of the DPI-driven master BFM. It keeps the same `axi4_if.master` attachment, but adds a command/response handshake, width and burst-length generalisation, per-beat data streams, and protocol/response checking.
- It sits between test sequences or firmware-model drivers and the SoC interconnect.

Parameters:
- DATA_WIDTH, 64: W/R data bits; power of two, 32..1024.
- ADDR_WIDTH, 32: AW/AR address bits.
- ID_WIDTH, 4: AWID/ARID width.
- MAX_BURST_LEN, 16: maximum beats per burst, 1..256.
- ID_VALUE, 0: constant ID driven on AWID/ARID.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- master  modport  axi4_if.master  AXI4 bus, widths matching the parameters
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine accepts command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  start address
- cmd_len  input  8  beats minus 1 (AXI LEN encoding)
- cmd_size  input  3  bytes per beat = 2^cmd_size
- cmd_burst  input  2  FIXED/INCR/WRAP encoding
- wd_valid / wd_ready  input / output  1 / 1  write-beat stream handshake
- wd_data  input  DATA_WIDTH  write beat
- wd_strb  input  DATA_WIDTH/8  write strobes
- rd_valid / rd_ready  output / input  1 / 1  read-beat stream handshake
- rd_data  output  DATA_WIDTH  read beat
- rd_last  output  1  final read beat
- done_valid  output  1  one-cycle completion pulse
- done_resp  output  2  worst-case response of the burst
- done_err  output  1  command rejected or beat-count mismatch

Behaviour:
- **Reset:** all outputs reset to 0 while reset is high, including all AXI VALID/READY outputs; FSM goes to IDLE.
  - Reset mid-burst abandons the transaction immediately; no done pulse is issued.
- **FSM states:** IDLE, AW, W, B, AR, R, DONE.
- **IDLE:** cmd_ready = 1. On cmd_valid && cmd_ready, register the command.
  - Reject the command (go to DONE with done_err = 1, done_resp = 2'b10, no bus activity) if any of:
    - cmd_len > MAX_BURST_LEN-1;
    - 2^cmd_size > DATA_WIDTH/8;
    - cmd_burst == 2'b11;
    - WRAP with cmd_len not in {1,3,7,15}.
  - Otherwise go to AW (write) or AR (read).
- **AW / AR:** AWVALID/ARVALID are asserted the cycle after acceptance and held with stable payload until READY.
  - LEN, SIZE, BURST and ID come from the registered command; cache/prot/lock/qos = 0.
- **W:** entered the cycle after the AW handshake; W is never issued before AW completes.
  - WVALID = wd_valid; wd_ready = WREADY; WDATA/WSTRB pass through combinationally.
  - An 8-bit beat counter increments on each W handshake. WLAST = (count == len). Go to B after the last beat.
- **B:** BREADY = 1; capture BRESP; go to DONE.
- **R:** RREADY = rd_ready; rd_valid = RVALID; rd_data = RDATA; rd_last = RLAST.
  - Track the worst response, ordered DECERR > SLVERR > OKAY > EXOKAY.
  - RLAST before beat len, or beat len without RLAST: set done_err and continue until RLAST.
- **DONE:** done_valid = 1 for exactly one cycle, then IDLE; cmd_ready returns on the following cycle.
  - Back-to-back minimum command period is therefore: write = 4 + beats cycles with zero-wait slave; read = 3 + beats.
- **Latency, zero-wait slave:** accept→AWVALID 1 cycle; last B handshake→done_valid 1 cycle.

Optional Feature:
- Macro: `AXI4_MASTER_BURST_ENGINE_STATS_EN`.
- **Defined:** adds outputs stat_wr_bursts[31:0], stat_rd_bursts[31:0], stat_err[15:0] and stat_busy_cycles[31:0].
  - Counters increment on each completed write burst, completed read burst, done_err/non-OKAY completion, and each non-IDLE cycle respectively.
  - All counters saturate rather than wrap and reset to 0.
- **Undefined:** ports and logic absent; core behaviour identical.

Decomposition:
- Package `axi4_master_pkg`:
  - state enum;
  - resp constants (OKAY, EXOKAY, SLVERR, DECERR);
  - burst constants;
  - function resp_worse(a, b);
  - function cmd_legal(len, size, burst, data_bytes).
- Sub-module `axi4_master_cmd_check`: combinational legality check plus registered command capture. All other logic stays in the top.

Test Plan:
- **INCR write:** addr 0x1000, len 3, size 3, INCR; zero-wait slave → AWLEN = 3; 4 W beats with WLAST on the 4th; BRESP OKAY → done_resp 0, done_err 0, done_valid 1 cycle after B.
- **Throttled read:** addr 0x2000, len 7; RDATA = beat index; rd_ready low every other cycle → rd_data 0..7 in order; rd_last only on beat 7; no beat dropped.
- **Illegal commands:** cmd_len 16 with MAX_BURST_LEN 16, then WRAP with len 2 → no AWVALID/ARVALID; done_err = 1, done_resp = 2'b10 the cycle after acceptance each time.
- **Mixed responses:** read len 3 with RRESP OKAY, SLVERR, OKAY, DECERR → done_resp = 2'b11.
- **Beat-count mismatch:** read len 3; slave asserts RLAST on beat 1 → done_err = 1; rd_last seen on beat 1; FSM returns to IDLE.
- **Reset mid-burst:** reset asserted mid-write after 2 of 4 W beats → AWVALID, WVALID and done_valid all 0 during reset. A new write is then accepted and completes normally; with STATS_EN, stat_wr_bursts = 1.
